// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0]  PS2_BAT_OK    = 8'hAA;
    localparam int unsigned PS2_DATA_BITS = 8;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Synchronous byte FIFO with first-word fall-through head and occupancy count.
module ps2_byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       pop,
    output logic [7:0]                 head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push_c;
    logic          do_pop_c;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop_c  = pop && !empty;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign do_push_c = push && (!full || do_pop_c);
    assign head      = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_fifo_receiver.sv
// PS/2 keyboard receiver: synchronise, deglitch, deframe, check, and queue bytes.
module ps2_rx_fifo_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          reset_required,
    output logic                          frame_error,
    output logic                          parity_error,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);

    // Index 0 carries ps2_clk, index 1 carries ps2_data.
    logic [1:0]             raw_c;
    logic [SYNC_STAGES-1:0] sync [2];
    logic [FCW-1:0]         fcnt [2];
    logic [1:0]             filt;
    logic                   clk_filt_d;

    assign raw_c = {ps2_data, ps2_clk};

    // Filtered line follows the synchronised line only after FILTER_LEN agreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                sync[i] <= '1;
                fcnt[i] <= '0;
            end
            filt       <= 2'b11;
            clk_filt_d <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync[i] <= {sync[i][SYNC_STAGES-2:0], raw_c[i]};
                if (sync[i][SYNC_STAGES-1] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FCW'(FILTER_LEN - 1)) begin
                    filt[i] <= sync[i][SYNC_STAGES-1];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FCW'(1);
                end
            end
            clk_filt_d <= filt[0];
        end
    end

    logic       fall_c;
    logic       data_bit_c;
    ps2_state_t state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       parity_bit;
    logic [TW-1:0] to_cnt;
    logic       good_c;
    logic       pop_c;
    logic       fifo_full;
    logic       fifo_empty;

    assign fall_c     = clk_filt_d && !filt[0];
    assign data_bit_c = filt[1];
    // The push happens on the stop edge itself so the byte is visible one cycle later.
    assign good_c     = fall_c && (state == STOP) && data_bit_c
                        && odd_parity_ok(shreg, parity_bit);
    assign pop_c      = rx_valid && rx_ready;
    assign rx_valid   = !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            shreg          <= '0;
            parity_bit     <= 1'b0;
            to_cnt         <= '0;
            reset_required <= 1'b0;
            frame_error    <= 1'b0;
            parity_error   <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            reset_required <= 1'b0;
            frame_error    <= 1'b0;
            parity_error   <= 1'b0;
            overflow       <= 1'b0;
            if (fall_c) begin
                to_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!data_bit_c) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg[bit_cnt] <= data_bit_c;
                        if (bit_cnt == 3'(PS2_DATA_BITS - 1)) begin
                            state <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    PARITY: begin
                        parity_bit <= data_bit_c;
                        state      <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!data_bit_c) begin
                            frame_error <= 1'b1;
                        end else if (!odd_parity_ok(shreg, parity_bit)) begin
                            parity_error <= 1'b1;
                        end else begin
                            reset_required <= (shreg == PS2_BAT_OK);
                            overflow       <= fifo_full && !pop_c;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                to_cnt <= '0;
            end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                frame_error <= 1'b1;
                state       <= IDLE;
                to_cnt      <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

    ps2_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (good_c),
        .push_data (shreg),
        .pop       (pop_c),
        .head      (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
